// File: rtl/mod_counter_pkg.sv
// Shared definitions for the configurable up/down counter and its prescaler.
// Mode encoding and the prescaler width helper live here so both files agree.
package mod_counter_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_WRAP    = 2'd0;
    localparam mode_t MODE_SAT     = 2'd1;
    localparam mode_t MODE_ONESHOT = 2'd2;
    localparam mode_t MODE_RSVD    = 2'd3;

    // Minimum of one bit so the prescaler register is always legal to declare.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Clock-enable divider: emits one tick every PRESCALE enabled cycles.
// With PRESCALE = 1 it degenerates to tick = enable and holds no state.
module counter_prescaler
    import mod_counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    if (PRESCALE <= 1) begin : g_bypass
        logic unused_ports;
        assign unused_ports = ^{clk, reset, clear};
        assign tick = enable;
    end else begin : g_count
        localparam int unsigned PW = clog2(PRESCALE);
        localparam logic [PW-1:0] LastPre = PW'(PRESCALE - 1);
        localparam logic [PW-1:0] OnePre  = PW'(1);

        logic [PW-1:0] pre_q, pre_d;
        logic          at_last;

        assign at_last = (pre_q == LastPre);
        assign tick    = enable && at_last;

        // clear covers both counter clear and parallel load.
        always_comb begin
            pre_d = pre_q;
            if (clear) begin
                pre_d = '0;
            end else if (enable) begin
                pre_d = at_last ? '0 : pre_q + OnePre;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                pre_q <= '0;
            end else begin
                pre_q <= pre_d;
            end
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Parametrised up/down counter with programmable limit, parallel load, wrap /
// saturate / one-shot terminal modes and an optional clock-enable prescaler.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned PRESCALE    = 1,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_clear,
    input  logic             io_enable,
    input  logic             io_up,
    input  logic             io_load,
    input  logic [WIDTH-1:0] io_loadValue,
    input  logic [WIDTH-1:0] io_limit,
    input  logic [1:0]       io_mode,
    output logic [WIDTH-1:0] io_value,
    output logic             io_full,
    output logic             io_empty,
    output logic             io_wrap,
    output logic             io_done
);

    localparam logic [WIDTH-1:0] ResetVal = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] One      = WIDTH'(1);

    logic [WIDTH-1:0] value_q, value_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic             tick;
    logic             step;
    logic             terminal;
    mode_t            mode;

    assign mode = mode_t'(io_mode);

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (io_clear | io_load),
        .enable (io_enable),
        .tick   (tick)
    );

    assign step = tick && !done_q;

    // >= rather than == so a lowered limit or an over-limit load still terminates.
    assign terminal = io_up ? (value_q >= io_limit) : (value_q == '0);

    always_comb begin
        value_d = value_q;
        wrap_d  = 1'b0;
        done_d  = done_q;
        if (io_clear) begin
            value_d = ResetVal;
            done_d  = 1'b0;
        end else if (io_load) begin
            value_d = io_loadValue;
            done_d  = 1'b0;
        end else if (step) begin
            if (!terminal) begin
                value_d = io_up ? value_q + One : value_q - One;
            end else begin
                case (mode)
                    MODE_SAT: begin
                        value_d = value_q;
                    end
                    MODE_ONESHOT: begin
                        done_d = 1'b1;
                        wrap_d = 1'b1;
                    end
                    default: begin
                        value_d = io_up ? '0 : io_limit;
                        wrap_d  = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= ResetVal;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            value_q <= value_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign io_value = value_q;
    assign io_full  = (value_q >= io_limit);
    assign io_empty = (value_q == '0);
    assign io_wrap  = wrap_q;
    assign io_done  = done_q;

endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
Parametrised up/down counter that supersedes the fixed 4-bit clear/full counter. It adds a programmable limit, a parallel load, direction control, three terminal-count modes (wrap, saturate, one-shot) and an optional clock-enable prescaler. Timer, PWM and sequencing blocks in the workshop designs instantiate it wherever a configurable tick or position counter is needed.

Parameters:
WIDTH, 4, counter width in bits (>=1)
PRESCALE, 1, number of enabled cycles per count step (>=1; 1 = step every enabled cycle)
RESET_VALUE, 0, value loaded on reset and on clear (must fit in WIDTH)

Ports:
clk  input  1  clock
reset  input  1  reset
io_clear  input  1  synchronous clear to RESET_VALUE
io_enable  input  1  count enable; also gates the prescaler
io_up  input  1  1 = count up, 0 = count down
io_load  input  1  parallel load strobe
io_loadValue  input  WIDTH  value taken on io_load
io_limit  input  WIDTH  terminal value for up-count, reload value for down-wrap
io_mode  input  2  0 = wrap, 1 = saturate, 2 = one-shot, 3 = reserved (behaves as wrap)
io_value  output  WIDTH  current count (registered)
io_full  output  1  io_value >= io_limit (combinational from register and input)
io_empty  output  1  io_value == 0
io_wrap  output  1  one-cycle registered pulse after a terminal event
io_done  output  1  sticky one-shot completion flag

Behaviour:
- Single clock clk; reset synchronous, active-high. Interface is synchronous only.
- Reset values: io_value = RESET_VALUE, prescaler = 0, io_wrap = 0, io_done = 0.
- Priority per edge: reset > io_clear > io_load > step.
  - io_clear: value <= RESET_VALUE; prescaler <= 0; done <= 0; wrap <= 0.
  - io_load: value <= io_loadValue; prescaler <= 0; done <= 0; wrap <= 0.
- Prescaler: internal counter 0..PRESCALE-1. It advances only when io_enable = 1 and there is no clear or load. tick = io_enable && (pre == PRESCALE-1), and pre wraps to 0 on tick. With PRESCALE = 1, tick = io_enable and no register is generated.
- step = tick && !io_done.
- Up step (io_up = 1):
  - value < limit: value + 1.
  - value >= limit (terminal; covers a lowered limit or a load above it):
    - wrap: value <= 0, wrap pulse.
    - saturate: hold, no pulse.
    - one-shot: hold, done <= 1, wrap pulse.
- Down step (io_up = 0):
  - value > 0: value - 1.
  - value == 0 (terminal):
    - wrap: value <= io_limit, wrap pulse.
    - saturate: hold, no pulse.
    - one-shot: hold, done <= 1, wrap pulse.
- Arithmetic is modulo 2^WIDTH, but reaching that wrap is impossible because terminal detection takes precedence. io_limit = 0 with up-count in wrap mode keeps value at 0 and pulses every step.
- io_wrap is registered: high for exactly the one cycle following the edge where the terminal event occurred, otherwise 0.
- io_done stays high until clear, load or reset. While done = 1, no steps occur, but the prescaler keeps cycling.
- io_mode, io_up and io_limit are sampled each edge. A change takes effect on the next step and never corrupts the value. A mode change does not clear done.
- io_enable = 0 freezes both value and prescaler.
- Reset mid-count overrides everything in the same edge.

Decomposition:
- Shared package mod_counter_pkg holds:
  - mode constants MODE_WRAP = 0, MODE_SAT = 1, MODE_ONESHOT = 2, and the 2-bit mode type.
  - prescaler width function clog2(PRESCALE).
- One sub-module, counter_prescaler (params PRESCALE; ports clk, reset, clear, enable, tick). It is generated as the constant tick = enable when PRESCALE = 1.
- Terminal detection and next-value logic stay in mod_counter.

Test Plan:
- WIDTH=4, PRESCALE=1, mode=0, up, limit=9, enable held 12 cycles from reset -> value 0..9, then 0, 1. io_full high while value = 9. io_wrap high only the cycle value reads 0 after 9.
- mode=1, down, start with load 2, enable 5 cycles -> value 2, 1, 0, 0, 0. io_empty high from value 0 on. io_wrap never asserted.
- mode=2, up, limit=3, enable 8 cycles -> value 0, 1, 2, 3, then holds 3. io_done rises with the single io_wrap pulse. Then io_load = 5 -> value 5, io_done = 0.
- PRESCALE=3, mode=0, up, limit=15, enable 9 cycles -> value increments once every 3 enabled cycles (ends at 3). Dropping enable for 2 cycles mid-way delays the next step by exactly 2 cycles.
- Same edge io_clear = 1, io_load = 1, io_loadValue = 7 -> value = RESET_VALUE (0). Next: io_load with a terminal step pending -> load wins, io_wrap = 0.
- Mid-count (value = 6) assert reset one cycle with enable high -> value = 0, io_wrap = 0, io_done = 0, prescaler restarts.
